// File: rtl/ksa_pkg.sv
// Shared types for the multi-precision Kogge-Stone adder: sequencer states and slice width.
package ksa_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ksa_state_e;

endpackage

// File: rtl/ksa_mp_seq_if.sv
// Operand/result handshake bundle for ksa_mp_seq.
// Carries op_sub when KSA_MP_SEQ_SUB_EN is defined.
interface ksa_mp_seq_if #(
    parameter int WORDS = 4
) ();
    localparam int W = 8 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef KSA_MP_SEQ_SUB_EN
    logic         op_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

`ifdef KSA_MP_SEQ_SUB_EN
    modport master (output in_valid, a, b, cin, op_sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, op_sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`endif

endinterface

// File: rtl/ksa_8.sv
// 8-bit Kogge-Stone adder slice with carry in/out; purely combinational.
module ksa_8
    import ksa_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] s_o,
    output logic               cout_o
);

    localparam int LVLS = $clog2(SLICE_W);

    // Each level lives in its own scope so the prefix tree has no self-referencing vector.
    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        logic [SLICE_W-1:0] gv;
        logic [SLICE_W-1:0] pv;
        if (l == 0) begin : g_init
            assign gv = a_i & b_i;
            assign pv = a_i ^ b_i;
        end else begin : g_step
            for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
                if (i >= (1 << (l - 1))) begin : g_merge
                    assign gv[i] = g_lvl[l-1].gv[i] |
                                   (g_lvl[l-1].pv[i] & g_lvl[l-1].gv[i-(1<<(l-1))]);
                    assign pv[i] = g_lvl[l-1].pv[i] & g_lvl[l-1].pv[i-(1<<(l-1))];
                end else begin : g_pass
                    assign gv[i] = g_lvl[l-1].gv[i];
                    assign pv[i] = g_lvl[l-1].pv[i];
                end
            end
        end
    end

    logic [SLICE_W:0] carry;

    assign carry[0]         = cin_i;
    assign carry[SLICE_W:1] = g_lvl[LVLS].gv | (g_lvl[LVLS].pv & {SLICE_W{cin_i}});
    assign s_o              = g_lvl[0].pv ^ carry[SLICE_W-1:0];
    assign cout_o           = carry[SLICE_W];

endmodule

// File: rtl/ksa_mp_seq.sv
// Multi-precision sequential adder: one ksa_8 slice reused LSB byte first, carry registered between bytes.
// Optional subtract mode (op_sub) is enabled by defining KSA_MP_SEQ_SUB_EN.
module ksa_mp_seq
    import ksa_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    ksa_mp_seq_if.slave bus
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    ksa_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               carry_q;
    logic [W-1:0]       sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic [W-1:0]       b_eff;
    logic               cin_eff;
    logic               accept;
    logic               last;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_cout;

`ifdef KSA_MP_SEQ_SUB_EN
    // Two's-complement subtract: invert B and force the initial carry.
    assign b_eff   = bus.op_sub ? ~bus.b : bus.b;
    assign cin_eff = bus.op_sub | bus.cin;
`else
    assign b_eff   = bus.b;
    assign cin_eff = bus.cin;
`endif

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign last    = (idx_q == IDX_W'(WORDS - 1));
    assign slice_a = a_q[SLICE_W*int'(idx_q) +: SLICE_W];
    assign slice_b = b_q[SLICE_W*int'(idx_q) +: SLICE_W];

    ksa_8 u_slice (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .s_o    (slice_s),
        .cout_o (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= bus.a;
                        b_q     <= b_eff;
                        carry_q <= cin_eff;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[SLICE_W*int'(idx_q) +: SLICE_W] <= slice_s;
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        cout_q <= slice_cout;
                        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (slice_s[SLICE_W-1] != a_q[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_mp_seq.sv
// Directed bench for ksa_mp_seq (WORDS=4) with a scoreboard of expected results.
module tb_ksa_mp_seq;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   lat;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ksa_mp_seq_if #(.WORDS(WORDS)) bus ();

    ksa_mp_seq #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic sub);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   t;
        be     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : c)};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic sub, output int n_lat);
        int n;
        n            = 0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
`ifdef KSA_MP_SEQ_SUB_EN
        bus.op_sub   = sub;
`endif
        while (!bus.in_ready && n < 20) begin
            tick;
            n++;
        end
        chk("accept_ready", W'(bus.in_ready), W'(1));
        sb.push_back(model(a, b, c, sub));
        tick;
        bus.in_valid = 1'b0;
        n_lat        = 1;
        while (!bus.out_valid && n_lat < 50) begin
            tick;
            n_lat++;
        end
        chk("out_valid_seen", W'(bus.out_valid), W'(1));
    endtask

    task automatic receive(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_sum"}, bus.sum, e.sum);
        chk({tag, "_cout"}, W'(bus.cout), W'(e.cout));
        chk({tag, "_ovf"}, W'(bus.ovf), W'(e.ovf));
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, W'(bus.out_valid), W'(0));
        chk({tag, "_idle_ready"}, W'(bus.in_ready), W'(1));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
`ifdef KSA_MP_SEQ_SUB_EN
        bus.op_sub    = 1'b0;
`endif
        tick;
        tick;
        chk("rst_in_ready", W'(bus.in_ready), W'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", W'(bus.in_ready), W'(1));
        chk("post_rst_out_valid", W'(bus.out_valid), W'(0));
        chk("post_rst_sum", bus.sum, '0);
        chk("post_rst_cout", W'(bus.cout), W'(0));
        chk("post_rst_ovf", W'(bus.ovf), W'(0));

        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, lat);
        chk("latency", W'(lat), W'(WORDS + 1));
        receive("byte_carry");

        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, lat);
        receive("ripple_all");

        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
        receive("pos_ovf");

        // Backpressure with a stray in_valid pulse while DONE.
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, lat);
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = (k == 1);
            bus.a        = 32'hDEAD_BEEF;
            bus.b        = 32'h0BAD_F00D;
            tick;
            chk("bp_sum", bus.sum, sb[0].sum);
            chk("bp_cout", W'(bus.cout), W'(sb[0].cout));
            chk("bp_ovf", W'(bus.ovf), W'(sb[0].ovf));
            chk("bp_in_ready", W'(bus.in_ready), W'(0));
            chk("bp_out_valid", W'(bus.out_valid), W'(1));
        end
        bus.in_valid = 1'b0;
        receive("bp_deliver");
        for (int k = 0; k < WORDS + 3; k++) begin
            tick;
            chk("bp_no_extra", W'(bus.out_valid), W'(0));
        end

        // Reset during the second RUN cycle discards the transaction.
        bus.in_valid = 1'b1;
        bus.a        = 32'h0000_0011;
        bus.b        = 32'h0000_0022;
        bus.cin      = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", W'(bus.out_valid), W'(0));
        chk("abort_sum", bus.sum, '0);
        chk("abort_cout", W'(bus.cout), W'(0));
        chk("abort_in_ready", W'(bus.in_ready), W'(1));
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
        chk("after_abort_latency", W'(lat), W'(WORDS + 1));
        receive("after_abort");

        for (int k = 0; k < 4; k++) begin
            send(32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)), 1'b0, lat);
            receive("random_add");
        end

`ifdef KSA_MP_SEQ_SUB_EN
        send(32'd5, 32'd7, 1'b0, 1'b1, lat);
        receive("sub_borrow");
        send(32'd7, 32'd5, 1'b0, 1'b1, lat);
        receive("sub_noborrow");
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, lat);
        receive("sub_ovf");
        send(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, lat);
        receive("sub_off_add");
`endif

        chk("sb_drained", W'(sb.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
